zap_wb_sram_ctrl: RTL and testbench

Wishbone B3 slave that terminates the processor's external Wishbone master port on a single-port synchronous SRAM with one-cycle read latency. It supports classic cycles and linear incrementing bursts (CTI 010 / 111), which the cache line fills and store-buffer drains generate. Acks are registered. Burst reads are pipelined with a predicted next address, so a burst streams one beat per cycle.

---
 rtl/zap_wb_sram_ctrl_pkg.sv | 18 +
 rtl/zap_wb_sram_addr_gen.sv | 30 +++
 rtl/zap_wb_sram_ctrl.sv | 130 +++++++++++++
 tb/tb_zap_wb_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-SRAM controller: cycle-type codes and FSM states.
package zap_wb_sram_ctrl_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    SRAM_IDLE   = 2'd0,
    SRAM_SINGLE = 2'd1,
    SRAM_BURST  = 2'd2
  } sram_state_e;

  function automatic logic cti_is_incr(input logic [2:0] cti);
    return cti == CTI_INCR;
  endfunction

endpackage

// File: rtl/zap_wb_sram_addr_gen.sv
// Predicted next-word address for burst reads, plus the compare that flags a
// master address that disagrees with the word whose data is being returned.
module zap_wb_sram_addr_gen #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  incr,
  input  logic [ADDR_WIDTH-1:0] cmp_addr,
  output logic [ADDR_WIDTH-1:0] exp_addr,
  output logic                  miss
);

  // Natural ADDR_WIDTH arithmetic gives the wrap at the top of the SRAM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exp_addr <= '0;
    end else if (load) begin
      exp_addr <= load_addr + ADDR_WIDTH'(1);
    end else if (incr) begin
      exp_addr <= exp_addr + ADDR_WIDTH'(1);
    end
  end

  // exp_addr already points one past the word whose read is in flight.
  assign miss = cmp_addr != (exp_addr - ADDR_WIDTH'(1));

endmodule

// File: rtl/zap_wb_sram_ctrl.sv
// Wishbone B3 slave on a single-port synchronous SRAM (1-cycle read latency).
// state | meaning: IDLE no beat pending; SINGLE classic ack cycle; BURST streaming acks.
module zap_wb_sram_ctrl
  import zap_wb_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic                  i_wb_we,
  input  logic [31:0]           i_wb_adr,
  input  logic [3:0]            i_wb_sel,
  input  logic [31:0]           i_wb_dat,
  input  logic [2:0]            i_wb_cti,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [31:0]           o_wb_dat,
  output logic                  o_sram_ce,
  output logic                  o_sram_we,
  output logic [3:0]            o_sram_ben,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [31:0]           o_sram_wdata,
  input  logic [31:0]           i_sram_rdata
);

  sram_state_e           state;
  logic                  ack_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_word;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic                  cmp_miss;
  logic                  request;
  logic                  live;
  logic                  burst_rd;
  logic                  mismatch;
  logic                  rd_idle;
  logic                  rd_burst;
  logic                  wr_commit;
  logic                  unused_adr;

  assign adr_word   = i_wb_adr[ADDR_WIDTH+1:2];
  assign unused_adr = ^{i_wb_adr[31:ADDR_WIDTH+2], i_wb_adr[1:0]};

  assign request = (state == SRAM_IDLE) && i_wb_cyc && i_wb_stb && !ack_q;
  // A change of direction mid-transfer counts as the master abandoning it.
  assign live      = i_wb_cyc && i_wb_stb && (i_wb_we == we_q);
  assign burst_rd  = (state == SRAM_BURST) && ack_q && live && !we_q;
  assign mismatch  = burst_rd && cmp_miss;
  assign rd_idle   = request && !i_wb_we;
  assign rd_burst  = burst_rd && !cmp_miss && cti_is_incr(i_wb_cti);
  assign wr_commit = ack_q && live && we_q;

  zap_wb_sram_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (i_clk),
    .reset_n   (i_reset_n),
    .load      (rd_idle),
    .load_addr (adr_word),
    .incr      (rd_burst),
    .cmp_addr  (adr_word),
    .exp_addr  (exp_addr),
    .miss      (cmp_miss)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= SRAM_IDLE;
      ack_q <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (request) begin
            ack_q <= 1'b1;
            we_q  <= i_wb_we;
            state <= cti_is_incr(i_wb_cti) ? SRAM_BURST : SRAM_SINGLE;
          end
        end
        SRAM_SINGLE: begin
          state <= SRAM_IDLE;
          ack_q <= 1'b0;
        end
        SRAM_BURST: begin
          if (!live || mismatch || !cti_is_incr(i_wb_cti)) begin
            state <= SRAM_IDLE;
            ack_q <= 1'b0;
          end
        end
        default: begin
          state <= SRAM_IDLE;
          ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_sram_ce    = 1'b0;
    o_sram_we    = 1'b0;
    o_sram_ben   = '0;
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    if (i_reset_n) begin
      if (wr_commit) begin
        o_sram_ce    = 1'b1;
        o_sram_we    = 1'b1;
        o_sram_ben   = i_wb_sel;
        o_sram_addr  = adr_word;
        o_sram_wdata = i_wb_dat;
      end else if (rd_idle) begin
        o_sram_ce   = 1'b1;
        o_sram_ben  = 4'hF;
        o_sram_addr = adr_word;
      end else if (rd_burst) begin
        o_sram_ce   = 1'b1;
        o_sram_ben  = 4'hF;
        o_sram_addr = exp_addr;
      end
    end
  end

  // Acks only go out against a live strobe so an abandoned beat is never acked.
  assign o_wb_ack = i_reset_n && ack_q && live && !mismatch;
  assign o_wb_err = i_reset_n && mismatch;
  assign o_wb_dat = (o_wb_ack || o_wb_err) ? i_sram_rdata : 32'h0;

endmodule

// File: tb/tb_zap_wb_sram_ctrl.sv
// Bench for zap_wb_sram_ctrl: SRAM model, reference memory, directed and random transfers.
module tb_zap_wb_sram_ctrl;

  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cyc, stb, we;
  logic [31:0]   adr;
  logic [3:0]    sel;
  logic [31:0]   wdat;
  logic [2:0]    cti;
  logic          ack, err;
  logic [31:0]   rdat;
  logic          sram_ce, sram_we;
  logic [3:0]    sram_ben;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [AW-1:0] last_wr_addr;
  logic [31:0]   last_rd;

  always #5 clk = ~clk;

  zap_wb_sram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_wb_cyc     (cyc),
    .i_wb_stb     (stb),
    .i_wb_we      (we),
    .i_wb_adr     (adr),
    .i_wb_sel     (sel),
    .i_wb_dat     (wdat),
    .i_wb_cti     (cti),
    .o_wb_ack     (ack),
    .o_wb_err     (err),
    .o_wb_dat     (rdat),
    .o_sram_ce    (sram_ce),
    .o_sram_we    (sram_we),
    .o_sram_ben   (sram_ben),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata)
  );

  // Synchronous SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_ben[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        wr_cnt++;
        last_wr_addr = sram_addr;
      end else begin
        rd_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [2:0] t, input logic [3:0] bs, input logic [31:0] d);
    cyc = c; stb = s; we = w; adr = a; cti = t; sel = bs; wdat = d;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] bs);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Wishbone master: n beats from base, one beat per ack. burst=0 gives a classic
  // cycle; drop=1 keeps CTI at incrementing and abandons the burst after n acks.
  // Entered and left just after a rising edge.
  task automatic do_xfer(input logic wr, input logic [31:0] base, input int n,
                         input logic burst, input logic drop,
                         input logic [31:0] d0, input logic [3:0] bs);
    int beat;
    int waited;
    logic [31:0] a, d;
    logic [2:0] t;
    beat = 0;
    waited = 0;
    while (beat < n) begin
      a = base + 32'(4 * beat);
      d = d0 ^ (32'(beat) * 32'h9E3779B9);
      if (!burst) t = 3'b000;
      else if (drop || beat < n - 1) t = 3'b010;
      else t = 3'b111;
      drive(1'b1, 1'b1, wr, a, t, bs, d);
      @(negedge clk);
      if (ack || err) begin
        chk("ack_latency", 32'(waited), (beat == 0) ? 32'd1 : 32'd0);
        chk("no_err", {31'd0, err}, 32'd0);
        if (wr) begin
          ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, bs);
        end else begin
          last_rd = rdat;
          chk("rd_data", rdat, ref_mem[widx(a)]);
        end
        beat++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 4) begin
          chk("ack_timeout", 32'(waited), 32'd1);
          beat = n;
        end
      end
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 4'h0, 32'h0);
    if (drop) begin
      @(negedge clk);
      chk("no_extra_ack", {30'd0, ack, err}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int r0, w0;
    logic wr;
    int kind, n, word;
    logic [31:0] base;

    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0;
    logic wr;
    int kind, n, word;
    logic [31:0] base;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom();
      ref_mem[i] = mem[i];
    end
    sram_rdata = 32'h0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_ce_we", {30'd0, sram_ce, sram_we}, 32'd0);
    chk("rst_ben", {28'd0, sram_ben}, 32'd0);
    chk("rst_addr", {20'd0, sram_addr}, 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Classic write then read of 0x40.
    do_xfer(1'b1, 32'h40, 1, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF);
    chk("wr_sram_addr", {20'd0, last_wr_addr}, 32'h10);
    do_xfer(1'b0, 32'h40, 1, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("rd_deadbeef", last_rd, 32'hDEADBEEF);

    // Byte-lane write.
    do_xfer(1'b1, 32'h44, 1, 1'b0, 1'b0, 32'h11223344, 4'hF);
    do_xfer(1'b1, 32'h44, 1, 1'b0, 1'b0, 32'h000000AA, 4'b0001);
    do_xfer(1'b0, 32'h44, 1, 1'b0, 1'b0, 32'h0, 4'h0);
    chk("byte_lane", last_rd, 32'h112233AA);

    // 4-beat read burst at 0x100: reads issued only in cycles 0..3.
    r0 = rd_cnt;
    do_xfer(1'b0, 32'h100, 4, 1'b1, 1'b0, 32'h0, 4'h0);
    chk("burst4_reads", 32'(rd_cnt - r0), 32'd4);
    @(negedge clk);
    chk("burst4_no_ack5", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;

    // Burst that wraps from word 0xFFF to word 0x000.
    do_xfer(1'b0, 32'h3FFC, 3, 1'b1, 1'b0, 32'h0, 4'h0);

    // Prediction error: second beat jumps to 0x200.
    drive(1'b1, 1'b1, 1'b0, 32'h100, 3'b010, 4'h0, 32'h0);
    @(negedge clk);
    chk("perr_beat1_wait", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("perr_beat1_ack", {30'd0, ack, err}, 32'd2);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h200, 3'b010, 4'h0, 32'h0);
    @(negedge clk);
    chk("perr_ack_err", {30'd0, ack, err}, 32'd1);
    @(posedge clk); #1;
    do_xfer(1'b0, 32'h200, 1, 1'b0, 1'b0, 32'h0, 4'h0);

    // Reset asserted during beat 2 of a read burst.
    drive(1'b1, 1'b1, 1'b0, 32'h300, 3'b010, 4'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h304, 3'b010, 4'h0, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {28'd0, sram_ce, sram_we, ack, err}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 4'h0, 32'h0);
    do_xfer(1'b0, 32'h10, 1, 1'b0, 1'b0, 32'h0, 4'h0);

    // Write burst abandoned after 2 beats.
    w0 = wr_cnt;
    do_xfer(1'b1, 32'h80, 2, 1'b1, 1'b1, 32'hCAFE0000, 4'hF);
    chk("drop_wr_count", 32'(wr_cnt - w0), 32'd2);
    do_xfer(1'b0, 32'h80, 1, 1'b0, 1'b0, 32'h0, 4'h0);
    do_xfer(1'b0, 32'h84, 1, 1'b0, 1'b0, 32'h0, 4'h0);

    // Random mix of classic, burst, single-beat EOB and abandoned bursts.
    for (int t = 0; t < 120; t++) begin
      wr = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      n = (kind == 1) ? $urandom_range(2, 6) : (kind == 3) ? $urandom_range(1, 4) : 1;
      word = ($urandom_range(0, 7) == 0) ? (DEPTH - $urandom_range(1, 3)) : $urandom_range(0, 63);
      base = ($urandom() & 32'hFFFFC000) | (32'(word) << 2) | 32'($urandom_range(0, 3));
      w0 = wr_cnt;
      do_xfer(wr, base, n, (kind != 0), (kind == 3), $urandom(), 4'($urandom_range(0, 15)));
      if (wr) chk("rand_wr_count", 32'(wr_cnt - w0), 32'(n));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("idle_no_ack", {30'd0, ack, err}, 32'd0);
        @(posedge clk); #1;
      end
    end

    // Read back the exercised region against the reference memory.
    for (int i = 0; i < 64; i++) do_xfer(1'b0, 32'(i) << 2, 1, 1'b0, 1'b0, 32'h0, 4'h0);
    do_xfer(1'b0, 32'((DEPTH - 4) << 2), 4, 1'b1, 1'b0, 32'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
